// File: rtl/l1_line_fill.sv
`default_nettype none
// ============================================================================
// Module   : l1_line_fill
// Brief    : Per-channel L1 fill controller; takes two-beat cache-line
//            responses, writes them into a per-stream ring of BRAM slots and
//            tracks per-stream occupancy with credits returned by the reader.
// Revision : 1.0
// ============================================================================
module l1_line_fill #(
    parameter int DATA_WIDTH = 64,
    parameter int WAYS       = 8,
    parameter int NSTRMS     = 16,
    parameter int NCL        = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                          clk1x,
    input  logic                          reset_n,
    input  logic                          i_v,
    output logic                          i_r,
    input  logic [$clog2(NSTRMS)-1:0]     i_st,
    input  logic [WAYS*DATA_WIDTH-1:0]    i_d,
    input  logic                          i_free_v,
    input  logic [$clog2(NSTRMS)-1:0]     i_free_st,
    input  logic                          i_flush_v,
    input  logic [$clog2(NSTRMS)-1:0]     i_flush_st,
    output logic                          o_we,
    output logic [ADDR_WIDTH-1:0]         o_wa,
    output logic [WAYS*DATA_WIDTH-1:0]    o_wd,
    output logic [NSTRMS-1:0]             o_avail,
    output logic                          o_err
);

    localparam int          SW     = $clog2(NSTRMS);
    localparam int          CW     = $clog2(NCL);
    localparam logic [CW:0] c_NCL  = (CW+1)'(NCL);
    localparam logic [CW-1:0] c_LAST = CW'(NCL-1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BEAT1 = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_st;
    logic [CW-1:0]   r_wp  [NSTRMS];
    logic [CW:0]     r_cnt [NSTRMS];

    logic            w_rdy;
    logic            w_acc;
    logic            w_flush_lock;
    logic            w_b0;
    logic            w_b1;
    logic            w_mis;
    logic            w_free_err;
    logic [NSTRMS-1:0] w_inc;
    logic [NSTRMS-1:0] w_dec;
    logic [NSTRMS-1:0] w_fl;

    always_comb begin
        w_rdy        = (r_state == S_BEAT1) ? 1'b1 : (r_cnt[i_st] < c_NCL);
        w_acc        = i_v & w_rdy;
        w_flush_lock = i_flush_v && (i_flush_st == r_st);
        w_b0         = w_acc && (r_state == S_IDLE);
        // A flush of the locked stream swallows the second beat unwritten.
        w_b1         = w_acc && (r_state == S_BEAT1) && (i_st == r_st) && !w_flush_lock;
        w_mis        = w_acc && (r_state == S_BEAT1) && (i_st != r_st);
        w_free_err   = i_free_v && (r_cnt[i_free_st] == '0);
        w_inc        = '0;
        w_dec        = '0;
        w_fl         = '0;
        w_inc[r_st]      = w_b1;
        w_dec[i_free_st] = i_free_v && (r_cnt[i_free_st] != '0);
        w_fl[i_flush_st] = i_flush_v;
    end

    assign i_r = w_rdy;

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NSTRMS; s++) begin
                r_cnt[s] <= '0;
                r_wp[s]  <= '0;
            end
            o_avail <= '0;
        end else begin
            for (int s = 0; s < NSTRMS; s++) begin
                if (w_fl[s]) begin
                    r_cnt[s] <= '0;
                    r_wp[s]  <= '0;
                end else begin
                    if (w_inc[s] && !w_dec[s]) begin
                        r_cnt[s] <= r_cnt[s] + 1'b1;
                    end else if (!w_inc[s] && w_dec[s]) begin
                        r_cnt[s] <= r_cnt[s] - 1'b1;
                    end
                    if (w_inc[s]) begin
                        r_wp[s] <= (r_wp[s] == c_LAST) ? '0 : r_wp[s] + 1'b1;
                    end
                end
                o_avail[s] <= (r_cnt[s] != '0);
            end
        end
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            o_we    <= 1'b0;
            o_wa    <= '0;
            o_wd    <= '0;
            o_err   <= 1'b0;
        end else begin
            o_we <= w_b0 | w_b1;
            if (w_b0) begin
                o_wa <= {i_st, r_wp[i_st], 1'b0};
                o_wd <= i_d;
            end else if (w_b1) begin
                o_wa <= {r_st, r_wp[r_st], 1'b1};
                o_wd <= i_d;
            end
            if (w_mis || w_free_err) begin
                o_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_b0) begin
                        r_st    <= i_st;
                        r_state <= S_BEAT1;
                    end
                end
                S_BEAT1: begin
                    if (w_flush_lock || w_b1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_line_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_line_fill
// Brief    : Self-checking bench for l1_line_fill: vector table of lines plus
//            hand sequences, BRAM writes checked against a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_l1_line_fill;

    logic         clk1x;
    logic         reset_n;
    logic         i_v;
    logic         i_r;
    logic [3:0]   i_st;
    logic [511:0] i_d;
    logic         i_free_v;
    logic [3:0]   i_free_st;
    logic         i_flush_v;
    logic [3:0]   i_flush_st;
    logic         o_we;
    logic [8:0]   o_wa;
    logic [511:0] o_wd;
    logic [15:0]  o_avail;
    logic         o_err;

    l1_line_fill dut (
        .clk1x      (clk1x),
        .reset_n    (reset_n),
        .i_v        (i_v),
        .i_r        (i_r),
        .i_st       (i_st),
        .i_d        (i_d),
        .i_free_v   (i_free_v),
        .i_free_st  (i_free_st),
        .i_flush_v  (i_flush_v),
        .i_flush_st (i_flush_st),
        .o_we       (o_we),
        .o_wa       (o_wa),
        .o_wd       (o_wd),
        .o_avail    (o_avail),
        .o_err      (o_err)
    );

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    typedef struct {
        logic [8:0]   wa;
        logic [511:0] wd;
    } wr_t;

    typedef struct {
        logic [3:0] st;
        logic [8:0] wa0;
        logic [8:0] wa1;
    } vec_t;

    wr_t  sb[$];
    wr_t  m_exp;
    vec_t tbl[5];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk1x) begin
        if (reset_n && o_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write to o_wa=%0d, required no write", o_wa);
            end else begin
                m_exp = sb.pop_front();
                if (o_wa !== m_exp.wa || o_wd !== m_exp.wd) begin
                    errors++;
                    $display("FAIL sb_write: got wa=%0d wd=%h, required wa=%0d wd=%h",
                             o_wa, o_wd, m_exp.wa, m_exp.wd);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk1x);
        #1;
    endtask

    // Offer one beat; side-band free/flush set by the caller last only the accept cycle.
    task automatic beat(input logic [3:0] st, input bit wr, input logic [8:0] wa);
        int          n;
        logic [511:0] d;
        d    = rnd512();
        i_v  = 1'b1;
        i_st = st;
        i_d  = d;
        n    = 0;
        @(negedge clk1x);
        while (!i_r && n < 50) begin
            @(negedge clk1x);
            n++;
        end
        if (!i_r) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: i_r=0 after 50 cycles, required 1 (st=%0d)", st);
            i_v = 1'b0;
        end else begin
            if (wr) sb.push_back('{wa: wa, wd: d});
            @(posedge clk1x);
            #1;
            i_v       = 1'b0;
            i_free_v  = 1'b0;
            i_flush_v = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{st: 4'd1,  wa0: 9'd32,  wa1: 9'd33};
        tbl[1] = '{st: 4'd7,  wa0: 9'd224, wa1: 9'd225};
        tbl[2] = '{st: 4'd15, wa0: 9'd480, wa1: 9'd481};
        tbl[3] = '{st: 4'd1,  wa0: 9'd34,  wa1: 9'd35};
        tbl[4] = '{st: 4'd9,  wa0: 9'd288, wa1: 9'd289};

        reset_n    = 1'b0;
        i_v        = 1'b0;
        i_st       = '0;
        i_d        = '0;
        i_free_v   = 1'b0;
        i_free_st  = '0;
        i_flush_v  = 1'b0;
        i_flush_st = '0;
        @(negedge clk1x);
        chk("rst_we",    64'(o_we),    64'd0);
        chk("rst_wa",    64'(o_wa),    64'd0);
        chk("rst_avail", 64'(o_avail), 64'd0);
        chk("rst_err",   64'(o_err),   64'd0);
        chk("rst_wd",    64'(o_wd[63:0]), 64'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        for (int v = 0; v < 5; v++) begin
            beat(tbl[v].st, 1'b1, tbl[v].wa0);
            beat(tbl[v].st, 1'b1, tbl[v].wa1);
        end
        idle(3);
        chk("tbl_avail", 64'(o_avail), 64'h8282);
        chk("tbl_err",   64'(o_err),   64'd0);

        // Fill stream 2 to capacity, then one credit lets the wrapped slot 0 through.
        for (int k = 0; k < 16; k++) begin
            beat(4'd2, 1'b1, 9'(64 + 2*k));
            beat(4'd2, 1'b1, 9'(65 + 2*k));
        end
        i_v  = 1'b1;
        i_st = 4'd2;
        @(negedge clk1x);
        chk("full_rdy0", 64'(i_r), 64'd0);
        @(negedge clk1x);
        chk("full_rdy1", 64'(i_r), 64'd0);
        @(posedge clk1x);
        #1;
        i_free_v  = 1'b1;
        i_free_st = 4'd2;
        @(posedge clk1x);
        #1;
        i_free_v = 1'b0;
        beat(4'd2, 1'b1, 9'd64);
        beat(4'd2, 1'b1, 9'd65);

        // Mismatched second beat: dropped, error latched, line still open on stream 3.
        beat(4'd3, 1'b1, 9'd96);
        beat(4'd4, 1'b0, 9'd0);
        idle(1);
        chk("mis_err", 64'(o_err), 64'd1);
        beat(4'd3, 1'b1, 9'd97);
        idle(3);
        chk("mis_avail3", 64'(o_avail[3]), 64'd1);
        chk("mis_avail4", 64'(o_avail[4]), 64'd0);

        // Completion and free on stream 5 in the same cycle.
        beat(4'd5, 1'b1, 9'd160);
        beat(4'd5, 1'b1, 9'd161);
        beat(4'd5, 1'b1, 9'd162);
        i_free_v  = 1'b1;
        i_free_st = 4'd5;
        beat(4'd5, 1'b1, 9'd163);
        idle(3);
        chk("cf_avail1", 64'(o_avail[5]), 64'd1);
        i_free_v  = 1'b1;
        i_free_st = 4'd5;
        idle(1);
        i_free_v = 1'b0;
        idle(3);
        chk("cf_avail0", 64'(o_avail[5]), 64'd0);
        beat(4'd5, 1'b1, 9'd164);
        beat(4'd5, 1'b1, 9'd165);

        // Flush stream 6 while its second line is half written.
        beat(4'd6, 1'b1, 9'd192);
        beat(4'd6, 1'b1, 9'd193);
        beat(4'd6, 1'b1, 9'd194);
        i_flush_v  = 1'b1;
        i_flush_st = 4'd6;
        beat(4'd6, 1'b0, 9'd0);
        idle(3);
        chk("fl_avail", 64'(o_avail[6]), 64'd0);
        beat(4'd6, 1'b1, 9'd192);
        beat(4'd6, 1'b1, 9'd193);

        // Reset pulse with stream 1 mid-line (cnt=2, wp=2).
        beat(4'd1, 1'b1, 9'd36);
        idle(1);
        reset_n = 1'b0;
        #2;
        chk("prst_we",    64'(o_we),    64'd0);
        chk("prst_wa",    64'(o_wa),    64'd0);
        chk("prst_wd",    64'(o_wd[63:0]), 64'd0);
        chk("prst_avail", 64'(o_avail), 64'd0);
        chk("prst_err",   64'(o_err),   64'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        beat(4'd1, 1'b1, 9'd32);
        beat(4'd1, 1'b1, 9'd33);

        // Free on empty stream 0.
        i_free_v  = 1'b1;
        i_free_st = 4'd0;
        idle(1);
        i_free_v = 1'b0;
        idle(3);
        chk("fe_err",   64'(o_err),   64'd1);
        chk("fe_avail", 64'(o_avail), 64'h0002);

        idle(3);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
